// File: rtl/capture_pkg.sv
// Shared state encoding, default trigger-path latency and the pre-trigger clamp.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int TRIG_LAT_DEF = 2;

    // Limit the pre-trigger window to one less than the record length (Depth 0 = 4096).
    function automatic logic [11:0] clamp_pre(input logic [11:0] depth, input logic [11:0] pre);
        logic [12:0] d;
        logic [12:0] dm1;
        d   = (depth == 12'd0) ? 13'd4096 : {1'b0, depth};
        dm1 = d - 13'd1;
        if ({1'b0, pre} >= d) clamp_pre = dm1[11:0];
        else                  clamp_pre = pre;
    endfunction

endpackage

// File: rtl/capture_ctrl_addr_window.sv
// 13-bit loadable down-counter; last flags the step that closes the window.
// The count sticks at zero, so a window of 0 or 1 closes on its first step.
module addr_window (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [12:0] load_val,
    input  logic        step,
    output logic        last
);

    logic [12:0] cnt_q;
    logic [12:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (step && cnt_q != 13'd0)
            cnt_d = cnt_q - 13'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last = step && (cnt_q <= 13'd1);

endmodule

// File: rtl/capture_ctrl.sv
// Sample-RAM acquisition sequencer: pre-fill, arm, trigger, post-fill, freeze, readout.
// All outputs registered; Waddr moves on the edge after each write slot.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int TRIG_LAT = TRIG_LAT_DEF,
    parameter int AUTO_W   = 16
) (
    input  logic              Wclk,
    input  logic              nRst,
    input  logic              Start,
    input  logic              Auto,
    input  logic [AUTO_W-1:0] Timeout,
    input  logic [11:0]       Depth,
    input  logic [11:0]       PreTrig,
    input  logic              Trig_Hit,
    input  logic [15:0]       Counter,
    input  logic              Rd_Next,
    input  logic              Rd_Rst,
    output logic [11:0]       Waddr,
    output logic [11:0]       Raddr,
    output logic [11:0]       Trig_Addr,
    output logic              Ready,
    output logic              Forced,
    output logic [2:0]        State
);

    localparam logic [11:0] TRIG_LAT_W = 12'(TRIG_LAT);

    state_t             state_q, state_d;
    logic [11:0]        waddr_q, waddr_d;
    logic [11:0]        raddr_q, raddr_d;
    logic [11:0]        trig_addr_q, trig_addr_d;
    logic               ready_q, ready_d;
    logic               forced_q, forced_d;
    logic [AUTO_W-1:0]  tcnt_q, tcnt_d;
    logic [12:0]        depth_q, depth_d;
    logic [11:0]        pre_q, pre_d;
    logic               auto_q, auto_d;
    logic [AUTO_W-1:0]  timeout_q, timeout_d;

    logic        step;
    logic        pre_load, post_load, done_entry;
    logic        pre_last, post_last;
    logic [11:0] rec_start;

    assign step      = (Counter < 16'd2);
    assign rec_start = trig_addr_q - pre_q;

    addr_window u_pre_win (
        .clk      (Wclk),
        .rst_n    (nRst),
        .load     (pre_load),
        .load_val ({1'b0, clamp_pre(Depth, PreTrig)}),
        .step     (step && state_q == ST_PRE),
        .last     (pre_last)
    );

    addr_window u_post_win (
        .clk      (Wclk),
        .rst_n    (nRst),
        .load     (post_load),
        .load_val (depth_q - {1'b0, pre_q}),
        .step     (step && state_q == ST_POST),
        .last     (post_last)
    );

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        trig_addr_d = trig_addr_q;
        ready_d     = ready_q;
        forced_d    = forced_q;
        tcnt_d      = tcnt_q;
        depth_d     = depth_q;
        pre_d       = pre_q;
        auto_d      = auto_q;
        timeout_d   = timeout_q;
        pre_load    = 1'b0;
        post_load   = 1'b0;
        done_entry  = 1'b0;

        if (step) begin
            case (state_q)
                ST_PRE: begin
                    waddr_d = waddr_q + 12'd1;
                    if (pre_last) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    waddr_d = waddr_q + 12'd1;
                    if (tcnt_q != {AUTO_W{1'b1}}) tcnt_d = tcnt_q + AUTO_W'(1);
                    // A real hit on the timeout step still counts as a real trigger.
                    if (Trig_Hit || (auto_q && tcnt_q == timeout_q)) begin
                        trig_addr_d = waddr_q - TRIG_LAT_W;
                        forced_d    = !Trig_Hit;
                        post_load   = 1'b1;
                        state_d     = ST_POST;
                    end
                end
                ST_POST: begin
                    waddr_d = waddr_q + 12'd1;
                    if (post_last) begin
                        state_d    = ST_DONE;
                        ready_d    = 1'b1;
                        done_entry = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (Start) begin
            state_d    = ST_PRE;
            waddr_d    = 12'd0;
            pre_load   = 1'b1;
            post_load  = 1'b0;
            done_entry = 1'b0;
            forced_d   = 1'b0;
            tcnt_d     = '0;
            ready_d    = 1'b0;
            depth_d    = (Depth == 12'd0) ? 13'd4096 : {1'b0, Depth};
            pre_d      = clamp_pre(Depth, PreTrig);
            auto_d     = Auto;
            timeout_d  = Timeout;
        end

        if (Rd_Rst)       raddr_d = rec_start;
        else if (Rd_Next) raddr_d = raddr_q + 12'd1;
        if (done_entry)   raddr_d = rec_start;
    end

    always_ff @(posedge Wclk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            raddr_q     <= '0;
            trig_addr_q <= '0;
            ready_q     <= 1'b0;
            forced_q    <= 1'b0;
            tcnt_q      <= '0;
            depth_q     <= '0;
            pre_q       <= '0;
            auto_q      <= 1'b0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            trig_addr_q <= trig_addr_d;
            ready_q     <= ready_d;
            forced_q    <= forced_d;
            tcnt_q      <= tcnt_d;
            depth_q     <= depth_d;
            pre_q       <= pre_d;
            auto_q      <= auto_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Waddr     = waddr_q;
    assign Raddr     = raddr_q;
    assign Trig_Addr = trig_addr_q;
    assign Ready     = ready_q;
    assign Forced    = forced_q;
    assign State     = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected records queued at trigger time, checked at Ready.
module tb_capture_ctrl;

    logic        Wclk = 1'b0;
    logic        nRst;
    logic        Start, Auto, Trig_Hit, Rd_Next, Rd_Rst;
    logic [15:0] Timeout, Counter;
    logic [11:0] Depth, PreTrig;
    logic [11:0] Waddr, Raddr, Trig_Addr;
    logic        Ready, Forced;
    logic [2:0]  State;

    typedef struct {
        logic [11:0] trig;
        logic [11:0] raddr;
        logic        forced;
        logic [11:0] waddr;
    } rec_t;

    rec_t        exp_q[$];
    logic [11:0] rd_q[$];
    logic [11:0] m_waddr, m_raddr, m_start;
    int          n_checks = 0;
    int          n_fail   = 0;

    capture_ctrl dut (
        .Wclk(Wclk), .nRst(nRst), .Start(Start), .Auto(Auto), .Timeout(Timeout),
        .Depth(Depth), .PreTrig(PreTrig), .Trig_Hit(Trig_Hit), .Counter(Counter),
        .Rd_Next(Rd_Next), .Rd_Rst(Rd_Rst), .Waddr(Waddr), .Raddr(Raddr),
        .Trig_Addr(Trig_Addr), .Ready(Ready), .Forced(Forced), .State(State)
    );

    always #5 Wclk = ~Wclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Wclk);
        #1;
    endtask

    task automatic rd_op(input logic nx, input logic rs);
        if (rs)      m_raddr = m_start;
        else if (nx) m_raddr = m_raddr + 12'd1;
        rd_q.push_back(m_raddr);
        Rd_Next = nx; Rd_Rst = rs;
        tick();
        Rd_Next = 1'b0; Rd_Rst = 1'b0;
        check_eq("raddr", 32'(Raddr), 32'(rd_q.pop_front()));
    endtask

    // abort_mode: 0 complete, 1 Start in POST, 2 nRst in POST
    task automatic run_capture(input logic [11:0] depth, input logic [11:0] pre, input logic au,
                               input logic [15:0] tmo, input int hit_k, input logic os,
                               input int abort_mode);
        int   de, pe, n_pre, n_post, k, c, phase;
        logic stp, hit;
        rec_t r;
        de     = (depth == 12'd0) ? 4096 : int'(depth);
        pe     = (int'(pre) >= de) ? de - 1 : int'(pre);
        n_pre  = (pe == 0) ? 1 : pe;
        n_post = de - pe;

        Start = 1'b1; Depth = depth; PreTrig = pre; Auto = au; Timeout = tmo;
        Counter = 16'd5; Trig_Hit = 1'b0;
        tick();
        Start = 1'b0; Depth = ~depth; PreTrig = ~pre; Auto = ~au; Timeout = ~tmo;
        check_eq("start_state", 32'(State), 1);
        check_eq("start_ready", 32'(Ready), 0);
        m_waddr = 12'd0; phase = 1; k = 0; c = 0;

        for (int cyc = 0; cyc < 20000 && phase < 4; cyc++) begin
            Counter  = os ? 16'(c % 8) : 16'd0;
            c++;
            stp      = (Counter < 16'd2);
            hit      = (phase == 2) && stp && (k == hit_k);
            Trig_Hit = (phase != 2) || hit || !stp;
            tick();
            if (stp) begin
                if (phase == 1) begin
                    m_waddr++; k++;
                    if (k == n_pre) begin
                        phase = 2; k = 0;
                        check_eq("armed_state", 32'(State), 2);
                    end
                end else if (phase == 2) begin
                    if (hit || (au && k == int'(tmo))) begin
                        r.trig   = m_waddr - 12'd2;
                        r.forced = !hit;
                        r.raddr  = r.trig - 12'(pe);
                        r.waddr  = m_waddr + 12'd1 + 12'(n_post);
                        exp_q.push_back(r);
                        phase = 3; k = 0;
                        check_eq("trig_state", 32'(State), 3);
                        check_eq("trig_ready", 32'(Ready), 0);
                    end else begin
                        k++;
                    end
                    m_waddr++;
                end else begin
                    m_waddr++; k++;
                    if (k == n_post) phase = 4;
                    else if (abort_mode != 0 && k == 3) phase = 5;
                end
            end
            check_eq("waddr", 32'(Waddr), 32'(m_waddr));
        end
        Trig_Hit = 1'b0;

        check_eq("trig_seen", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            if (abort_mode == 0) begin
                check_eq("done_state", 32'(State), 4);
                check_eq("done_ready", 32'(Ready), 1);
                check_eq("trig_addr", 32'(Trig_Addr), 32'(r.trig));
                check_eq("raddr_start", 32'(Raddr), 32'(r.raddr));
                check_eq("forced", 32'(Forced), 32'(r.forced));
                check_eq("done_waddr", 32'(Waddr), 32'(r.waddr));
                m_start = r.raddr; m_raddr = r.raddr;
                Counter = 16'd0;
                repeat (3) tick();
                check_eq("hold_waddr", 32'(Waddr), 32'(r.waddr));
                check_eq("hold_state", 32'(State), 4);
            end else if (abort_mode == 1) begin
                Start = 1'b1; Depth = 12'd20; PreTrig = 12'd2; Auto = 1'b0; Counter = 16'd0;
                tick();
                Start = 1'b0;
                check_eq("abort_state", 32'(State), 1);
                check_eq("abort_ready", 32'(Ready), 0);
                check_eq("abort_waddr", 32'(Waddr), 0);
                repeat (100) tick();
                check_eq("abort_armed", 32'(State), 2);
                check_eq("abort_no_done", 32'(Ready), 0);
            end else begin
                #2 nRst = 1'b0;
                #1;
                check_eq("arst_state", 32'(State), 0);
                check_eq("arst_waddr", 32'(Waddr), 0);
                check_eq("arst_raddr", 32'(Raddr), 0);
                check_eq("arst_trig", 32'(Trig_Addr), 0);
                check_eq("arst_ready", 32'(Ready), 0);
                check_eq("arst_forced", 32'(Forced), 0);
                #2 nRst = 1'b1;
                tick();
                check_eq("arst_idle", 32'(State), 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; Start = 1'b0; Auto = 1'b0; Trig_Hit = 1'b0; Rd_Next = 1'b0; Rd_Rst = 1'b0;
        Timeout = 16'd0; Counter = 16'd5; Depth = 12'd0; PreTrig = 12'd0;
        repeat (2) tick();
        check_eq("rst_state", 32'(State), 0);
        check_eq("rst_waddr", 32'(Waddr), 0);
        check_eq("rst_raddr", 32'(Raddr), 0);
        check_eq("rst_trig", 32'(Trig_Addr), 0);
        check_eq("rst_ready", 32'(Ready), 0);
        check_eq("rst_forced", 32'(Forced), 0);
        nRst = 1'b1;
        tick();

        run_capture(12'd1000, 12'd200, 1'b0, 16'd0, 300, 1'b0, 0);
        repeat (5) rd_op(1'b1, 1'b0);
        rd_op(1'b0, 1'b1);
        rd_op(1'b1, 1'b1);

        Start = 1'b1; Rd_Next = 1'b1; Counter = 16'd5; Depth = 12'd50; PreTrig = 12'd10;
        tick();
        Start = 1'b0; Rd_Next = 1'b0;
        check_eq("start_rdnext_state", 32'(State), 1);
        check_eq("start_rdnext_raddr", 32'(Raddr), 32'(m_raddr + 12'd1));
        check_eq("start_rdnext_ready", 32'(Ready), 0);

        run_capture(12'd16, 12'd4, 1'b0, 16'd0, 5, 1'b1, 0);
        run_capture(12'd100, 12'd10, 1'b1, 16'd50, -1, 1'b0, 0);
        run_capture(12'd100, 12'd10, 1'b1, 16'd50, 50, 1'b0, 0);
        run_capture(12'd16, 12'd100, 1'b0, 16'd0, 2, 1'b0, 0);
        run_capture(12'd8, 12'd0, 1'b0, 16'd0, 0, 1'b0, 0);
        run_capture(12'd0, 12'd4095, 1'b0, 16'd0, 10, 1'b0, 0);
        rd_op(1'b1, 1'b0);
        run_capture(12'd8, 12'd3, 1'b0, 16'd0, 1, 1'b0, 0);
        rd_op(1'b1, 1'b0);
        rd_op(1'b0, 1'b1);
        run_capture(12'd40, 12'd5, 1'b0, 16'd0, 3, 1'b0, 1);
        run_capture(12'd40, 12'd5, 1'b0, 16'd0, 3, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
